// File: rtl/vga_text_write_arbiter.sv
// Character-buffer write-port arbiter: debugger vs. FIFO-buffered CPU console, plus a clear engine.
// Optional macro VGA_ARB_DROP_CNT_EN adds the cpu_stall_cnt output (CPU back-pressure cycle counter).
module vga_text_write_arbiter #(
  parameter int          ADDR_W     = 12,
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter int          NUM_CELLS  = 2400,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dbg_valid,
  output logic                            dbg_ready,
  input  logic [ADDR_W-1:0]               dbg_addr,
  input  logic [DATA_W-1:0]               dbg_data,
  input  logic                            cpu_valid,
  output logic                            cpu_ready,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [DATA_W-1:0]               cpu_data,
  input  logic                            clr_start,
  output logic                            clr_busy,
  output logic [$clog2(FIFO_DEPTH):0]     cpu_fifo_level,
  output logic                            display_wen,
  output logic [ADDR_W-1:0]               display_w_addr,
  output logic [DATA_W-1:0]               display_w_data
`ifdef VGA_ARB_DROP_CNT_EN
  ,
  output logic [15:0]                     cpu_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t                     state;
  logic                       rr_last;
  logic [ADDR_W-1:0]          cnt;
  logic [ADDR_W+DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [LVL_W-1:0]           level;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       serve_ok;
  logic                       grant_dbg;
  logic                       grant_cpu;
  logic [ADDR_W+DATA_W-1:0]   head;

  assign fifo_full      = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty     = (level == '0);
  assign cpu_ready      = !fifo_full;
  assign cpu_fifo_level = level;
  assign push           = cpu_valid && cpu_ready;
  assign head           = fifo_mem[rd_ptr];

  // rr_last=1 means the CPU won the previous grant, so the debugger takes the next tie.
  assign serve_ok  = (state == SERVE) && !clr_start;
  assign grant_dbg = serve_ok && dbg_valid && (fifo_empty || rr_last);
  assign grant_cpu = serve_ok && !fifo_empty && (!dbg_valid || !rr_last);
  assign dbg_ready = grant_dbg;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cpu_addr, cpu_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= SERVE;
      rr_last        <= 1'b1;
      cnt            <= '0;
      clr_busy       <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      display_wen    <= 1'b0;
      display_w_addr <= '0;
      display_w_data <= '0;
    end else begin
      display_wen <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (grant_cpu) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !grant_cpu) begin
        level <= level + LVL_W'(1);
      end else if (!push && grant_cpu) begin
        level <= level - LVL_W'(1);
      end

      case (state)
        SERVE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            cnt      <= '0;
          end else if (grant_dbg) begin
            display_wen    <= 1'b1;
            display_w_addr <= dbg_addr;
            display_w_data <= dbg_data;
            rr_last        <= 1'b0;
          end else if (grant_cpu) begin
            display_wen    <= 1'b1;
            display_w_addr <= head[ADDR_W+DATA_W-1:DATA_W];
            display_w_data <= head[DATA_W-1:0];
            rr_last        <= 1'b1;
          end
        end
        CLEAR: begin
          display_wen    <= 1'b1;
          display_w_addr <= cnt;
          display_w_data <= DATA_W'(CLEAR_CHAR);
          if (cnt == ADDR_W'(NUM_CELLS - 1)) begin
            state    <= SERVE;
            cnt      <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

`ifdef VGA_ARB_DROP_CNT_EN
  // Saturating count of cycles the CPU was held off by a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_stall_cnt <= '0;
    end else if (clr_start) begin
      cpu_stall_cnt <= '0;
    end else if (cpu_valid && !cpu_ready && (cpu_stall_cnt != 16'hFFFF)) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_text_write_arbiter.sv
// Self-checking bench for vga_text_write_arbiter: queue-based reference model plus directed literal checks.
// Define VGA_ARB_DROP_CNT_EN for both files to exercise cpu_stall_cnt.
module tb_vga_text_write_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int NUM_CELLS = 2400;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              dbg_valid = 1'b0;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data = '0;
  logic              cpu_valid = 1'b0;
  logic              cpu_ready;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic              clr_start = 1'b0;
  logic              clr_busy;
  logic [2:0]        cpu_fifo_level;
  logic              display_wen;
  logic [ADDR_W-1:0] display_w_addr;
  logic [DATA_W-1:0] display_w_data;
`ifdef VGA_ARB_DROP_CNT_EN
  logic [15:0]       cpu_stall_cnt;
`endif

  vga_text_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_valid      (dbg_valid),
    .dbg_ready      (dbg_ready),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_addr       (cpu_addr),
    .cpu_data       (cpu_data),
    .clr_start      (clr_start),
    .clr_busy       (clr_busy),
    .cpu_fifo_level (cpu_fifo_level),
    .display_wen    (display_wen),
    .display_w_addr (display_w_addr),
    .display_w_data (display_w_data)
`ifdef VGA_ARB_DROP_CNT_EN
    ,
    .cpu_stall_cnt  (cpu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: CPU FIFO as a queue, clear as a remaining-cell index, last winner as a flag.
  logic [19:0] mq[$];
  logic [19:0] wlog[$];
  bit          m_last_cpu = 1'b1;
  bit          m_clear    = 1'b0;
  int          m_idx      = 0;
  bit          exp_wen    = 1'b0;
  int          exp_addr   = 0;
  int          exp_data   = 0;
  int          m_stall    = 0;
  int          streak     = 0;
  int          busy_cycles = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      m_last_cpu = 1'b1;
      m_clear    = 1'b0;
      m_idx      = 0;
      exp_wen    = 1'b0;
      m_stall    = 0;
      streak     = 0;
      check("rst_wen",   32'(display_wen),    0);
      check("rst_addr",  32'(display_w_addr), 0);
      check("rst_data",  32'(display_w_data), 0);
      check("rst_busy",  32'(clr_busy),       0);
      check("rst_level", 32'(cpu_fifo_level), 0);
    end else begin
      int  size;
      bit  ready_c;
      bit  exp_dbg_ready;
      bit  pick_cpu;
      size          = mq.size();
      ready_c       = (size < DEPTH);
      exp_dbg_ready = !m_clear && !clr_start && dbg_valid && (size == 0 || m_last_cpu);

      check("wen", 32'(display_wen), 32'(exp_wen));
      if (exp_wen) begin
        check("w_addr", 32'(display_w_addr), exp_addr);
        check("w_data", 32'(display_w_data), exp_data);
      end
      check("clr_busy",  32'(clr_busy),       32'(m_clear));
      check("level",     32'(cpu_fifo_level), size);
      check("cpu_ready", 32'(cpu_ready),      32'(ready_c));
      check("dbg_ready", 32'(dbg_ready),      32'(exp_dbg_ready));
`ifdef VGA_ARB_DROP_CNT_EN
      check("stall_cnt", 32'(cpu_stall_cnt), m_stall);
`endif
      if (display_wen) wlog.push_back({display_w_addr, display_w_data});
      if (clr_busy) busy_cycles++;

      exp_wen = 1'b0;
      if (m_clear) begin
        exp_wen  = 1'b1;
        exp_addr = m_idx;
        exp_data = 32'h20;
        m_idx++;
        if (m_idx == NUM_CELLS) begin
          m_clear = 1'b0;
          m_idx   = 0;
        end
      end else if (clr_start) begin
        m_clear = 1'b1;
        m_idx   = 0;
      end else if (dbg_valid || size > 0) begin
        pick_cpu = (size > 0) && (!dbg_valid || !m_last_cpu);
        exp_wen  = 1'b1;
        if (pick_cpu) begin
          logic [19:0] h;
          h        = mq.pop_front();
          exp_addr = 32'(h[19:8]);
          exp_data = 32'(h[7:0]);
        end else begin
          exp_addr = 32'(dbg_addr);
          exp_data = 32'(dbg_data);
        end
        m_last_cpu = pick_cpu;
        if (pick_cpu && dbg_valid) begin
          streak++;
          check("dbg_starve", 32'(streak <= 1), 1);
        end else begin
          streak = 0;
        end
      end
      if (!dbg_valid) streak = 0;

      if (clr_start) m_stall = 0;
      else if (cpu_valid && !ready_c && m_stall < 65535) m_stall++;

      if (cpu_valid && ready_c) mq.push_back({cpu_addr, cpu_data});
    end
  end

  task automatic idle_inputs();
    dbg_valid = 1'b0;
    cpu_valid = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((clr_busy || cpu_fifo_level != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 5000), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Holds each requester valid until its writes are accepted; clr_start pulses on slot clr_at.
  task automatic run_writes(input int nd, input logic [11:0] dbase, input int nc,
                            input logic [11:0] cbase, input int clr_at, input int budget);
    int di = 0;
    int ci = 0;
    int cyc = 0;
    bit acc_d, acc_c;
    while ((di < nd || ci < nc) && cyc < budget) begin
      dbg_valid = (di < nd);
      dbg_addr  = dbase + 12'(di);
      dbg_data  = 8'(8'hA0 + di);
      cpu_valid = (ci < nc);
      cpu_addr  = cbase + 12'(ci);
      cpu_data  = 8'(8'hC0 + ci);
      clr_start = (cyc == clr_at);
      @(negedge clk);
      acc_d = dbg_ready;
      acc_c = cpu_valid && cpu_ready;
      @(posedge clk);
      #2;
      if (acc_d) di++;
      if (acc_c) ci++;
      cyc++;
    end
    idle_inputs();
    check("run_timeout", 32'(di == nd && ci == nc), 1);
    wait_idle();
  endtask

  task automatic expect_log(input string name, input int idx, input logic [19:0] val);
    check(name, (idx < wlog.size()) ? 32'(wlog[idx]) : 32'hDEAD_BEEF, 32'(val));
  endtask

  logic [19:0] t2_exp [7] = '{20'h020A0, 20'h100C0, 20'h021A1, 20'h101C1,
                              20'h022A2, 20'h102C2, 20'h023A3};
  logic [19:0] t4_tail [6] = '{20'h100C0, 20'h031A1, 20'h101C1,
                               20'h102C2, 20'h103C3, 20'h104C4};

  initial begin
    int  errs;
    bit  found;

    // Debugger only: four back-to-back writes.
    reset_dut();
    wlog.delete();
    run_writes(4, 12'h010, 0, 12'h000, -1, 50);
    check("t1_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) expect_log("t1_log", i, {12'(16 + i), 8'(8'hA0 + i)});

    // Debugger and CPU contending: strict alternation, CPU in push order.
    reset_dut();
    wlog.delete();
    run_writes(4, 12'h020, 3, 12'h100, -1, 50);
    check("t2_count", wlog.size(), 7);
    for (int i = 0; i < 7; i++) expect_log("t2_log", i, t2_exp[i]);

    // Clear with two queued CPU entries; FIFO fills during the clear.
    reset_dut();
    wlog.delete();
    busy_cycles = 0;
    run_writes(2, 12'h030, 5, 12'h100, 1, 4000);
    check("t4_busy_cycles", busy_cycles, NUM_CELLS);
    check("t4_count", wlog.size(), 1 + NUM_CELLS + 6);
    expect_log("t4_first", 0, 20'h030A0);
    errs = 0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (i + 1 >= wlog.size() || wlog[i + 1] !== {12'(i), 8'h20}) errs++;
    end
    check("t4_clear_seq_errors", errs, 0);
    expect_log("t4_last_cell", NUM_CELLS, 20'h95F20);
    for (int i = 0; i < 6; i++) expect_log("t4_tail", 1 + NUM_CELLS + i, t4_tail[i]);

    // Reset in the middle of a clear.
    reset_dut();
    clr_start = 1'b1;
    @(posedge clk);
    #2 clr_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (display_wen && display_w_addr == 12'd1000) found = 1'b1;
    end
    check("t5_reach_1000", 32'(found), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_async_wen",  32'(display_wen),    0);
    check("t5_async_addr", 32'(display_w_addr), 0);
    check("t5_async_busy", 32'(clr_busy),       0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    wlog.delete();
    repeat (20) @(posedge clk);
    #2;
    check("t5_no_writes", wlog.size(), 0);
    check("t5_busy_low",  32'(clr_busy), 0);

`ifdef VGA_ARB_DROP_CNT_EN
    // Full FIFO held off for ten cycles while the clear stalls draining.
    reset_dut();
    clr_start = 1'b1;
    @(posedge clk);
    #2 clr_start = 1'b0;
    cpu_valid = 1'b1;
    cpu_addr  = 12'h200;
    cpu_data  = 8'h5A;
    repeat (14) @(posedge clk);
    #2 cpu_valid = 1'b0;
    @(negedge clk);
    check("t6_stall_10", 32'(cpu_stall_cnt), 10);
    wait_idle();
    check("t6_stall_kept", 32'(cpu_stall_cnt), 10);
    clr_start = 1'b1;
    @(posedge clk);
    #2 clr_start = 1'b0;
    @(negedge clk);
    check("t6_stall_clr", 32'(cpu_stall_cnt), 0);
    wait_idle();
`endif

    // Randomized traffic with an early forced clear and rare random clears.
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      dbg_valid = ($urandom_range(0, 9) < 7);
      dbg_addr  = 12'($urandom);
      dbg_data  = 8'($urandom);
      cpu_valid = ($urandom_range(0, 9) < 7);
      cpu_addr  = 12'($urandom);
      cpu_data  = 8'($urandom);
      clr_start = (c == 500) || ($urandom_range(0, 1499) == 0);
      @(posedge clk);
      #2;
    end
    idle_inputs();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
